// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing and frame-length constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 4;
    localparam int START_BITS           = 1;
    localparam int DATA_BITS            = 8;

    // Serial bits in one frame for a given parity/stop configuration.
    function automatic int frame_bits(input int parity_en, input int stop_bits);
        return START_BITS + DATA_BITS + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Reloadable baud down-counter. Counts from CLKS_PER_BIT-1 to 0 and holds at 0;
// tick_o is high for the single cycle the enabled count sits at 0.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic load_i,
    output logic tick_o
);

    localparam int               CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: a reload wins, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, 8N1/8E1/8O1/8N2-style serial output,
// registered tx line and a one-cycle done pulse after the last stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic       ODD_BIT   = (PARITY_ODD != 0);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        accept;
    logic        baud_en;
    logic        baud_load;
    logic        tick;

    assign din_ready = (state_q == ST_IDLE);
    assign busy      = !din_ready;
    assign accept    = din_valid && din_ready;
    assign baud_en   = (state_q != ST_IDLE);
    assign tx        = tx_q;
    assign done      = done_q;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .en_i  (baud_en),
        .load_i(baud_load),
        .tick_o(tick)
    );

    // Next-state, shift register, bit index and tx line decisions for the frame.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        baud_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d   = ST_START;
                    shift_d   = din;
                    parity_d  = (^din) ^ ODD_BIT;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    baud_load = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    baud_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    baud_load = 1'b1;
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    tx_d      = 1'b1;
                    baud_load = 1'b1;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (bit_idx_q == LAST_STOP) begin
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        baud_load = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_idx_d = '0;
                tx_d      = 1'b1;
            end
        endcase
    end

    // Frame state registers; reset parks the line high and drops any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..1023.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts a parity bit after data bit 7.
REQ-003 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 din  input  8  byte to transmit; sampled only on an accepted handshake.
REQ-008 din_valid  input  1  din holds a byte to send.
REQ-009 din_ready  output  1  block can accept a byte this cycle.
REQ-010 tx  output  1  serial line; idle high; registered output.
REQ-011 busy  output  1  frame in progress (any state except IDLE).
REQ-012 done  output  1  one-cycle pulse after the last stop bit completes.

Function
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP; any illegal encoding returns to IDLE.
REQ-014 din_ready SHALL equal 1 exactly when the state is IDLE.
REQ-015 A byte SHALL be accepted on the rising edge where din_valid=1 and din_ready=1; din is latched into a shift register, and the parity bit is computed from it at that edge.
REQ-016 On acceptance, state -> START and the bit counter loads CLKS_PER_BIT-1; tx=0 from the next cycle.
REQ-017 Every serial bit SHALL drive tx for exactly CLKS_PER_BIT cycles; the baud counter counts down and the bit advances when it reaches 0.
REQ-018 DATA SHALL send 8 bits LSB first, shifting right; a 3-bit index counts 0..7, and the state leaves DATA after index 7.
REQ-019 PARITY is entered only if PARITY_EN=1; tx = XOR of the 8 data bits, inverted when PARITY_ODD=1.
REQ-020 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-021 done SHALL be 1 in the first IDLE cycle after STOP and 0 in every other cycle.
REQ-022 tx SHALL be 1 in IDLE; the minimum start-to-start spacing of back-to-back frames is (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT+1 cycles.
REQ-023 A handshake asserted in the done cycle SHALL be accepted in that same cycle.
REQ-024 din and din_valid SHALL be ignored while busy=1; a change on din mid-frame does not alter the bits sent.
REQ-025 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never wrap below 0.

Reset
REQ-026 While reset=0: state=IDLE, tx=1, busy=0, done=0, and din_ready=1 after release; all counters and the shift register are 0.
REQ-027 Assertion of reset mid-frame SHALL force tx=1 asynchronously and abort the frame; no done pulse is produced.
REQ-028 The first handshake SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 Package uart_pkg SHALL hold the state encoding typedef, the default CLKS_PER_BIT and the frame-length constants, shared with the receiver.
REQ-030 One sub-module, uart_baud_tick, SHALL hold the reloadable down-counter and emit a one-cycle tick at 0; the FSM and shift register stay in uart_tx.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-031 Reset, then send 0xA5 with PARITY_EN=0 -> tx = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; done pulses once, 41 cycles after acceptance.
REQ-032 Hold din_valid high with 0x00 then 0xFF -> second start bit begins 41 cycles after the first; tx between frames is high for exactly 1 cycle.
REQ-033 PARITY_EN=1, PARITY_ODD=0, send 0xA5 -> parity bit 0; PARITY_ODD=1 -> parity bit 1; frame is 44 cycles.
REQ-034 STOP_BITS=2, send 0x3C -> tx high for 8 cycles after data bit 7 before done pulses.
REQ-035 Assert reset during data bit 3 -> tx=1 within the same cycle, no done pulse; after release, 0x5A is transmitted correctly.
REQ-036 Loopback: tx drives the team's UART receiver at the same CLKS_PER_BIT over 256 bytes -> every received dout equals the sent din.
